vector_harness: RTL
===================

# vector_harness

Sequential stimulus and response-compaction harness that sits around one combinational test DUT, such as the width and signedness probe modules. It sweeps the DUT input exhaustively from 0 to 2^A_WIDTH−1, samples the DUT output after a programmable settle delay, and folds every sample into a MISR signature. When the sweep finishes it compares the signature against an expected value. Signatures produced by different synthesis/simulation flows are compared to expose semantic mismatches.

## Interface
- A_WIDTH, 4: DUT input width, 1..16.
- Y_WIDTH, 24: DUT output width, 1..SIG_WIDTH.
- SIG_WIDTH, 32: MISR width, 8..32.
- SIG_POLY, 32'h04C11DB7: feedback polynomial. Only the low SIG_WIDTH bits are used.
- SETTLE, 1: wait cycles before each sample, 0..7.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  sweep request. Sampled only in IDLE or DONE.
- expected  in  SIG_WIDTH  golden signature.
- dut_a  out  A_WIDTH  stimulus to the DUT, registered.
- dut_y  in  Y_WIDTH  DUT response, unsigned.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete. Held until the next start.
- signature  out  SIG_WIDTH  current MISR value.
- vec_count  out  A_WIDTH+1  number of vectors sampled.
- match  out  1  done && (signature == expected).

## Operation
- Reset values:
  - state=IDLE
  - dut_a=0, busy=0, done=0, vec_count=0, match=0
  - signature=SEED (all ones)
  - settle counter=0
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start=1: load signature=SEED, dut_a=0, vec_count=0, done=0, busy=1. Go to SETTLE if SETTLE>0, otherwise SAMPLE.
- SETTLE: counter runs from 0 to SETTLE−1. On the last count, go to SAMPLE.
- SAMPLE, at the clock edge:
  - signature ← (signature<<1) ^ (signature[MSB] ? SIG_POLY : 0) ^ zero-extend(dut_y).
  - vec_count increments.
  - If dut_a is all ones: go to DONE with busy=0, done=1, dut_a holds.
  - Otherwise: dut_a+1, then SETTLE (or SAMPLE if SETTLE=0).
- Width rules:
  - dut_y is zero-extended to SIG_WIDTH and never sign-extended.
  - The shift discards the MSB.
  - All arithmetic is unsigned.
  - dut_a wrap-around never occurs, because the sweep stops at all ones.
- start while busy is ignored. There is no restart mid-sweep.
- start in DONE restarts the sweep. done drops at that same edge.
- match is combinational from the registered signature and `expected`. It is 0 whenever done=0.
- rst_n asserted mid-sweep: immediate return to reset values. The partial signature is lost.
- Parameter check: SETTLE>7 or Y_WIDTH>SIG_WIDTH is an elaboration error.

## Timing
- Start is sampled at edge 0. dut_a=0 and busy=1 are visible after edge 0.
- Each vector occupies SETTLE+1 cycles. dut_y is sampled at the final edge of its slot.
- Busy duration is 2^A_WIDTH·(SETTLE+1) cycles.
- done rises at the edge of the last sample. The final signature and vec_count=2^A_WIDTH are valid in the same cycle.
- The DUT must be combinational, or have latency ≤ SETTLE cycles.

## Structure
- Package vector_harness_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE)
  - SEED = all-ones
  - the default polynomial constant
- Sub-module sig_misr (params WIDTH and POLY):
  - ports: clk, rst_n, init, en, din[WIDTH], sig[WIDTH]
  - init loads SEED and has priority over en.
- The top level contains the FSM, settle counter, stimulus counter, vec_count and match logic.

## Test plan
All scenarios use A_WIDTH=2, Y_WIDTH=4, SIG_WIDTH=8, POLY=8'h07, SETTLE=0 unless stated.
- Identity DUT (y={2'b0,a}), start pulse:
  - signature steps FF→F9→F4→ED→DE
  - done at edge 4, busy for 4 cycles, vec_count=4
  - match=1 with expected=8'hDE.
- Constant DUT (y=0): final signature 8'hDD. With expected=8'hDE, match=0, done=1.
- SETTLE=2, identity DUT:
  - dut_a changes every 3 cycles
  - busy for 12 cycles, final signature 8'hDE (identical).
- start pulsed again during the sweep (edge 2) is ignored, final result unchanged. start in DONE restarts: done=0 next cycle and signature reloads FF.
- rst_n low at cycle 2 of a sweep:
  - asynchronous return to dut_a=0, busy=0, signature=FF
  - a new start yields 8'hDE.
- A_WIDTH=1, SETTLE=0, y=a: signature FF→F9→F4, done after 2 cycles, vec_count=2.

Source files
------------

// File: rtl/vector_harness_pkg.sv
// Shared types and constants for the exhaustive-sweep MISR harness.
package vector_harness_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [31:0] SEED       = 32'hFFFF_FFFF;
   localparam logic [31:0] DEF_POLY   = 32'h04C1_1DB7;
   localparam int unsigned SETTLE_MAX = 7;
   localparam int unsigned CNT_W      = 3;

endpackage

// File: rtl/vector_harness_misr.sv
// Multiple-input signature register: Galois shift-left with polynomial feedback.
module sig_misr
   import vector_harness_pkg::*;
#(
   parameter int unsigned      WIDTH = 32,
   parameter logic [WIDTH-1:0] POLY  = DEF_POLY[WIDTH-1:0]
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sig
);

   logic [WIDTH-1:0] sig_nxt;

   // init has priority so a restart always begins from the seed
   always_comb begin
      sig_nxt = sig;
      if (init) begin
         sig_nxt = SEED[WIDTH-1:0];
      end else if (en) begin
         sig_nxt = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig <= SEED[WIDTH-1:0];
      else        sig <= sig_nxt;
   end

endmodule

// File: rtl/vector_harness.sv
// Sweeps a combinational DUT input 0..2^A_WIDTH-1 and compacts its responses into a MISR.
module vector_harness
   import vector_harness_pkg::*;
#(
   parameter int unsigned A_WIDTH   = 4,
   parameter int unsigned Y_WIDTH   = 24,
   parameter int unsigned SIG_WIDTH = 32,
   parameter logic [31:0] SIG_POLY  = DEF_POLY,
   parameter int unsigned SETTLE    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [SIG_WIDTH-1:0] expected,
   output logic [A_WIDTH-1:0]   dut_a,
   input  logic [Y_WIDTH-1:0]   dut_y,
   output logic                 busy,
   output logic                 done,
   output logic [SIG_WIDTH-1:0] signature,
   output logic [A_WIDTH:0]     vec_count,
   output logic                 match
);

   localparam int unsigned     VC_W     = A_WIDTH + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam state_t          FIRST    = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

   if (SETTLE > SETTLE_MAX || Y_WIDTH > SIG_WIDTH || Y_WIDTH < 1 ||
       A_WIDTH < 1 || A_WIDTH > 16 || SIG_WIDTH < 8 || SIG_WIDTH > 32) begin : g_param_err
      $error("vector_harness: illegal parameter combination");
   end

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [A_WIDTH-1:0] dut_a_nxt;
   logic [VC_W-1:0]    vec_nxt;
   logic               busy_nxt, done_nxt;
   logic               misr_init_c, misr_en_c;

   // next-state and datapath updates
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      dut_a_nxt   = dut_a;
      vec_nxt     = vec_count;
      busy_nxt    = busy;
      done_nxt    = done;
      misr_init_c = 1'b0;
      misr_en_c   = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               misr_init_c = 1'b1;
               dut_a_nxt   = '0;
               vec_nxt     = '0;
               cnt_nxt     = '0;
               busy_nxt    = 1'b1;
               done_nxt    = 1'b0;
               state_nxt   = FIRST;
            end
         end
         ST_SETTLE: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = ST_SAMPLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_SAMPLE: begin
            misr_en_c = 1'b1;
            vec_nxt   = vec_count + VC_W'(1);
            // last vector: stop without wrapping the stimulus
            if (dut_a == '1) begin
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = ST_DONE;
            end else begin
               dut_a_nxt = dut_a + A_WIDTH'(1);
               state_nxt = FIRST;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         dut_a     <= '0;
         vec_count <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         dut_a     <= dut_a_nxt;
         vec_count <= vec_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   sig_misr #(
      .WIDTH (SIG_WIDTH),
      .POLY  (SIG_POLY[SIG_WIDTH-1:0])
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (misr_init_c),
      .en    (misr_en_c),
      .din   (SIG_WIDTH'(dut_y)),
      .sig   (signature)
   );

   assign match = done && (signature == expected);

endmodule
